uart_core_os: RTL and testbench

//  Single-clock UART transceiver. Successor to the split clk_gen/uart_tx/uart_rx chain.
//  Per-direction clock-enable baud dividers replace derived clocks.
//  RX uses a parametrised oversample rate with 3-sample majority voting.

---
 rtl/uart_core_os_if.sv | 14 +
 rtl/uart_core_os.sv | 183 ++++++++++++++++++
 tb/tb_uart_core_os.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/uart_core_os_if.sv
// uart_core_os_if: valid/ready bus between the register layer and the UART core
interface uart_core_os_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_overrun;
  modport master(output tx_valid, tx_data, rx_ready, input tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun);
  modport slave(input tx_valid, tx_data, rx_ready, output tx_ready, rx_valid, rx_data, rx_parity_err, rx_frame_err, rx_overrun);
endinterface

// File: rtl/uart_core_os.sv
// uart_core_os: single-clock UART transceiver with oversampled majority-vote RX
module uart_core_os #(
  parameter int DIV_W = 16,
  parameter int OVS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0]       length,
  input  logic             parity_en,
  input  logic             parity_type,
  input  logic             stop2,
  output logic             tx,
  output logic             tx_busy,
  input  logic             rx,
  uart_core_os_if.slave    bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  localparam int TW = $clog2(OVS);
  localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
  localparam logic [TW-1:0] T_S0 = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1 = TW'(OVS / 2);
  localparam logic [TW-1:0] T_S2 = TW'(OVS / 2 + 1);
  logic [3:0] len_eff;
  logic [7:0] mask;
  assign len_eff = (length >= 4'd5 && length <= 4'd8) ? length : 4'd8;
  assign mask = 8'hFF >> (4'd8 - len_eff);
  state_t tx_st, tx_nx;
  logic [DIV_W-1:0] tx_div, tx_div_l;
  logic [TW-1:0] tx_tk;
  logic [2:0] tx_bit, tx_len;
  logic [7:0] tx_sh;
  logic tx_par, tx_pen, tx_s2, tx_acc, tx_end;
  assign tx_acc = bus.tx_valid && bus.tx_ready;
  assign tx_end = tx_div == tx_div_l && tx_tk == T_LAST;
  // TX state register; reset forces IDLE so tx returns high at once
  always_ff @(posedge clk or posedge rst)
    if (rst) tx_st <= IDLE;
    else tx_st <= tx_nx;
  // TX next state: advance only on the last tick of each bit
  always_comb begin
    tx_nx = tx_st;
    case (tx_st)
      IDLE:    tx_nx = tx_acc ? START : IDLE;
      START:   tx_nx = tx_end ? DATA : START;
      DATA:    tx_nx = !tx_end ? DATA : tx_bit != tx_len ? DATA : tx_pen ? PARITY : STOP1;
      PARITY:  tx_nx = tx_end ? STOP1 : PARITY;
      STOP1:   tx_nx = !tx_end ? STOP1 : tx_s2 ? STOP2 : IDLE;
      STOP2:   tx_nx = tx_end ? IDLE : STOP2;
      default: tx_nx = IDLE;
    endcase
  end
  // TX outputs decoded from state
  always_comb begin
    bus.tx_ready = tx_st == IDLE;
    tx_busy = tx_st != IDLE;
    tx = tx_st == START ? 1'b0 : tx_st == DATA ? tx_sh[0] : tx_st == PARITY ? tx_par : 1'b1;
  end
  // TX datapath: latch config on accept, divider restarts so bit edges are exact
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_div <= '0;
      tx_div_l <= '0;
      tx_tk <= '0;
      tx_bit <= '0;
      tx_len <= 3'd7;
      tx_sh <= '0;
      tx_par <= 1'b0;
      tx_pen <= 1'b0;
      tx_s2 <= 1'b0;
    end else if (tx_acc) begin
      tx_div <= '0;
      tx_div_l <= baud_div;
      tx_tk <= '0;
      tx_bit <= '0;
      tx_len <= 3'(len_eff - 4'd1);
      tx_sh <= bus.tx_data;
      tx_par <= ^(bus.tx_data & mask) ^ parity_type;
      tx_pen <= parity_en;
      tx_s2 <= stop2;
    end else if (tx_st != IDLE) begin
      tx_div <= tx_div == tx_div_l ? '0 : tx_div + 1'b1;
      if (tx_div == tx_div_l) tx_tk <= tx_tk == T_LAST ? '0 : tx_tk + 1'b1;
      if (tx_end && tx_st == DATA) begin
        tx_sh <= tx_sh >> 1;
        tx_bit <= tx_bit + 1'b1;
      end
    end
  logic [1:0] rx_sy;
  logic rx_s;
  assign rx_s = rx_sy[1];
  // RX synchroniser, idles high like the line
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_sy <= 2'b11;
    else rx_sy <= {rx_sy[0], rx};
  state_t rx_st, rx_nx;
  logic [DIV_W-1:0] rx_div, rx_div_l;
  logic [TW-1:0] rx_tk;
  logic [2:0] rx_bit, rx_len;
  logic [7:0] rx_sh;
  logic rx_pen, rx_pty, rx_s2, rx_v0, rx_v1, rx_perr, rx_ferr;
  logic rx_tick, rx_dec, rx_end, rx_maj, rx_done;
  // RX state register
  always_ff @(posedge clk or posedge rst)
    if (rst) rx_st <= IDLE;
    else rx_st <= rx_nx;
  // RX next state: final stop bit leaves at its decision point to catch the next start edge
  always_comb begin
    rx_nx = rx_st;
    case (rx_st)
      IDLE:    rx_nx = rx_s ? IDLE : START;
      START:   rx_nx = rx_dec && rx_maj ? IDLE : rx_end ? DATA : START;
      DATA:    rx_nx = !rx_end ? DATA : rx_bit != rx_len ? DATA : rx_pen ? PARITY : STOP1;
      PARITY:  rx_nx = rx_end ? STOP1 : PARITY;
      STOP1:   rx_nx = rx_done ? IDLE : rx_end ? STOP2 : STOP1;
      STOP2:   rx_nx = rx_done ? IDLE : STOP2;
      default: rx_nx = IDLE;
    endcase
  end
  // RX strobes: tick, mid-bit decision, bit end, 3-sample majority, word complete
  always_comb begin
    rx_tick = rx_div == rx_div_l;
    rx_dec = rx_tick && rx_tk == T_S2;
    rx_end = rx_tick && rx_tk == T_LAST;
    rx_maj = (rx_v0 & rx_v1) | (rx_v0 & rx_s) | (rx_v1 & rx_s);
    rx_done = rx_dec && (rx_st == STOP2 || (rx_st == STOP1 && !rx_s2));
  end
  // RX datapath: latch config on start detect, sample, shift and accumulate errors
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_div <= '0;
      rx_div_l <= '0;
      rx_tk <= '0;
      rx_bit <= '0;
      rx_len <= 3'd7;
      rx_sh <= '0;
      rx_pen <= 1'b0;
      rx_pty <= 1'b0;
      rx_s2 <= 1'b0;
      rx_v0 <= 1'b1;
      rx_v1 <= 1'b1;
      rx_perr <= 1'b0;
      rx_ferr <= 1'b0;
    end else if (rx_st == IDLE) begin
      if (!rx_s) begin
        rx_div <= '0;
        rx_div_l <= baud_div;
        rx_tk <= '0;
        rx_bit <= '0;
        rx_len <= 3'(len_eff - 4'd1);
        rx_sh <= '0;
        rx_pen <= parity_en;
        rx_pty <= parity_type;
        rx_s2 <= stop2;
        rx_perr <= 1'b0;
        rx_ferr <= 1'b0;
      end
    end else begin
      rx_div <= rx_tick ? '0 : rx_div + 1'b1;
      if (rx_tick) rx_tk <= rx_tk == T_LAST ? '0 : rx_tk + 1'b1;
      if (rx_tick && rx_tk == T_S0) rx_v0 <= rx_s;
      if (rx_tick && rx_tk == T_S1) rx_v1 <= rx_s;
      if (rx_dec && rx_st == DATA) rx_sh <= {rx_maj, rx_sh[7:1]};
      if (rx_dec && rx_st == PARITY) rx_perr <= ^rx_sh ^ rx_maj ^ rx_pty;
      if (rx_dec && (rx_st == STOP1 || rx_st == STOP2) && !rx_maj) rx_ferr <= 1'b1;
      if (rx_end && rx_st == DATA) rx_bit <= rx_bit + 1'b1;
    end
  // RX output register with valid/ready hold and overrun flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.rx_valid <= 1'b0;
      bus.rx_data <= '0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err <= 1'b0;
      bus.rx_overrun <= 1'b0;
    end else if (rx_done) begin
      bus.rx_valid <= 1'b1;
      bus.rx_data <= rx_sh >> (3'd7 - rx_len);
      bus.rx_parity_err <= rx_perr;
      bus.rx_frame_err <= rx_ferr | !rx_maj;
      bus.rx_overrun <= bus.rx_valid && !bus.rx_ready;
    end else if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
endmodule

// File: tb/tb_uart_core_os.sv
// tb_uart_core_os: scoreboard bench for the oversampling UART core
module tb_uart_core_os;
  localparam int BIT = 64;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic [3:0] length = 4'd8;
  logic parity_en = 1'b0, parity_type = 1'b0, stop2 = 1'b0;
  logic tx, tx_busy, rx;
  logic rx_drv = 1'b1, loop = 1'b0;
  int checks = 0, failures = 0;
  logic [10:0] exp_q[$];
  uart_core_os_if bus();
  uart_core_os #(.DIV_W(16), .OVS(16)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .length(length), .parity_en(parity_en),
    .parity_type(parity_type), .stop2(stop2), .tx(tx), .tx_busy(tx_busy), .rx(rx), .bus(bus)
  );
  assign rx = loop ? tx : rx_drv;
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // monitor: every consumed word is checked against the oldest expectation
  always @(negedge clk)
    if (!rst && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rx_unexpected: got word %0h with no expected word", bus.rx_data);
      end else chk("rx_word", {21'd0, bus.rx_data, bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, {21'd0, exp_q.pop_front()});
    end
  task automatic run_tx(logic [7:0] d, int exp_len, int par_idx, logic exp_par);
    int n = 0;
    while (!bus.tx_ready && n < 3000) begin
      tick(1);
      n++;
    end
    bus.tx_valid = 1'b1;
    bus.tx_data = d;
    tick(1);
    bus.tx_valid = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.tx_ready || n > 3000) break;
      n++;
      if (n == BIT / 2) chk("tx_start_bit", {31'd0, tx}, 32'd0);
      if (n == par_idx * BIT + BIT / 2) chk("tx_parity_bit", {31'd0, tx}, {31'd0, exp_par});
    end
    chk("tx_frame_len", n, exp_len);
    chk("tx_busy_end", {31'd0, tx_busy}, 32'd0);
  endtask
  task automatic drive_rx(logic [7:0] d, logic pen, logic pb, logic sb);
    rx_drv = 1'b0;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(BIT);
    end
    if (pen) begin
      rx_drv = pb;
      tick(BIT);
    end
    rx_drv = sb;
    tick(BIT);
    rx_drv = 1'b1;
    tick(2 * BIT);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = 8'h00;
    bus.rx_ready = 1'b1;
    tick(2);
    @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_tx_ready", {31'd0, bus.tx_ready}, 32'd1);
    chk("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rx_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, bus.rx_data}, 32'd0);
    chk("rst_flags", {29'd0, bus.rx_parity_err, bus.rx_frame_err, bus.rx_overrun}, 32'd0);
    tick(1);
    rst = 1'b0;
    tick(4);
    loop = 1'b1;
    length = 4'd8;
    parity_en = 1'b1;
    parity_type = 1'b1;
    stop2 = 1'b0;
    exp_q.push_back({8'hA5, 3'b000});
    run_tx(8'hA5, 11 * BIT, 9, 1'b1);
    tick(BIT);
    length = 4'd5;
    parity_type = 1'b0;
    stop2 = 1'b1;
    exp_q.push_back({8'h1F, 3'b000});
    run_tx(8'hFF, 9 * BIT, 6, 1'b1);
    tick(BIT);
    loop = 1'b0;
    length = 4'd8;
    stop2 = 1'b0;
    exp_q.push_back({8'h03, 3'b100});
    drive_rx(8'h03, 1'b1, 1'b1, 1'b1);
    exp_q.push_back({8'h03, 3'b010});
    drive_rx(8'h03, 1'b1, 1'b0, 1'b0);
    parity_en = 1'b0;
    rx_drv = 1'b0;
    tick(16);
    rx_drv = 1'b1;
    tick(3 * BIT);
    exp_q.push_back({8'h5A, 3'b000});
    drive_rx(8'h5A, 1'b0, 1'b0, 1'b1);
    bus.rx_ready = 1'b0;
    drive_rx(8'h11, 1'b0, 1'b0, 1'b1);
    drive_rx(8'h22, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("rx_hold_valid", {31'd0, bus.rx_valid}, 32'd1);
    exp_q.push_back({8'h22, 3'b001});
    tick(1);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("rx_valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'h00;
    tick(1);
    bus.tx_valid = 1'b0;
    tick(3 * BIT + BIT / 2);
    chk("tx_mid_data", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    chk("tx_async_rst", {31'd0, tx}, 32'd1);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    chk("tx_ready_after_rst", {31'd0, bus.tx_ready}, 32'd1);
    chk("tx_busy_after_rst", {31'd0, tx_busy}, 32'd0);
    tick(4);
    loop = 1'b1;
    exp_q.push_back({8'hC3, 3'b000});
    run_tx(8'hC3, 10 * BIT, -1, 1'b0);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
